// File: rtl/serial_mag_cmp.sv
// rtl/serial_mag_cmp.sv - MSB-first digit-serial magnitude comparator with early exit
// Optional two's-complement compare enabled by defining SERIAL_MAG_CMP_SIGNED_EN.
module serial_mag_cmp #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_MAG_CMP_SIGNED_EN
  input  logic             is_signed,
`endif
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             xeqy,
  output logic             xgty,
  output logic             xlty
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_xs, r_ys;
  logic [WIDTH-1:0] w_xin, w_yin;
  logic [CW-1:0]    r_cnt;
  logic [DIGIT-1:0] w_xd, w_yd;
  logic             w_gt, w_lt, w_last, w_flip;

`ifdef SERIAL_MAG_CMP_SIGNED_EN
  // Flipping the sign bit maps two's complement order onto unsigned order.
  assign w_flip = is_signed;
`else
  assign w_flip = 1'b0;
`endif

  assign w_xin  = x ^ {w_flip, {(WIDTH-1){1'b0}}};
  assign w_yin  = y ^ {w_flip, {(WIDTH-1){1'b0}}};
  assign w_xd   = r_xs[WIDTH-1 -: DIGIT];
  assign w_yd   = r_ys[WIDTH-1 -: DIGIT];
  assign w_gt   = (w_xd > w_yd);
  assign w_lt   = (w_xd < w_yd);
  assign w_last = (r_cnt == CW'(NDIG - 1));

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (w_gt || w_lt || w_last) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_xs    <= '0;
      r_ys    <= '0;
      r_cnt   <= '0;
      xeqy    <= 1'b0;
      xgty    <= 1'b0;
      xlty    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_xs  <= w_xin;
            r_ys  <= w_yin;
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          if (w_gt) begin
            xgty <= 1'b1;
            xeqy <= 1'b0;
            xlty <= 1'b0;
          end else if (w_lt) begin
            xlty <= 1'b1;
            xeqy <= 1'b0;
            xgty <= 1'b0;
          end else if (w_last) begin
            xeqy <= 1'b1;
            xgty <= 1'b0;
            xlty <= 1'b0;
          end else begin
            r_xs  <= r_xs << DIGIT;
            r_ys  <= r_ys << DIGIT;
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mag_cmp.sv
// tb/tb_serial_mag_cmp.sv - directed bench for serial_mag_cmp (WIDTH=16, DIGIT=4)
module tb_serial_mag_cmp;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] x, y;
  logic        busy, done, xeqy, xgty, xlty;
`ifdef SERIAL_MAG_CMP_SIGNED_EN
  logic        is_signed = 1'b0;
`endif
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  serial_mag_cmp #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef SERIAL_MAG_CMP_SIGNED_EN
    .is_signed(is_signed),
`endif
    .x(x), .y(y), .busy(busy), .done(done),
    .xeqy(xeqy), .xgty(xgty), .xlty(xlty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch a compare and check latency, busy length and flags at done.
  task automatic run_cmp(input logic [15:0] a, input logic [15:0] b, input int k_exp,
                         input logic e, input logic g, input logic l, input string tag);
    int k, bcnt;
    k = 0;
    bcnt = 0;
    @(negedge clk);
    x = a; y = b; start = 1'b1;
    tick();
    start = 1'b0;
    if (busy) bcnt++;
    while (!done && k < 40) begin
      tick();
      k++;
      if (busy) bcnt++;
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_lat"}, k, k_exp);
    chk({tag, "_busy"}, bcnt, k_exp);
    chk({tag, "_flags"}, {e ^ xeqy, g ^ xgty, l ^ xlty}, 0);
    chk({tag, "_flagval"}, {xeqy, xgty, xlty}, {e, g, l});
    tick();
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int dn, k;
    rst = 1'b1; start = 1'b0; x = '0; y = '0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_flags", {xeqy, xgty, xlty}, 0);
    rst = 1'b0;

    run_cmp(16'h1234, 16'h1234, 4, 1, 0, 0, "eq");
    run_cmp(16'h8000, 16'h7FFF, 1, 0, 1, 0, "early_gt");
    run_cmp(16'h12F0, 16'h1300, 2, 0, 0, 1, "dig2_lt");
    run_cmp(16'h1230, 16'h1231, 4, 0, 0, 1, "last_lt");
    tick();
    tick();
    tick();
    chk("hold_flags", {xeqy, xgty, xlty}, 3'b001);

    // start pulsed mid-RUN must be ignored
    @(negedge clk);
    x = 16'h0001; y = 16'h0002; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; x = 16'hFFFF;
    tick();
    start = 1'b0;
    dn = 0;
    k = 0;
    while (!done && k < 20) begin
      tick();
      k++;
    end
    chk("hs_done", done, 1);
    chk("hs_lat", k, 2);
    chk("hs_flags", {xeqy, xgty, xlty}, 3'b001);
    // hold start through DONE: relaunch only from IDLE
    start = 1'b1; x = 16'h8000; y = 16'h7FFF;
    tick();
    chk("hs_done_ignored_busy", busy, 0);
    chk("hs_done_ignored_done", done, 0);
    tick();
    start = 1'b0;
    chk("hs_relaunch_busy", busy, 1);
    tick();
    chk("hs_relaunch_done", done, 1);
    chk("hs_relaunch_flags", {xeqy, xgty, xlty}, 3'b010);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) dn++;
    end
    chk("hs_no_extra_done", dn, 0);

    // reset in the 3rd RUN cycle discards the compare
    @(negedge clk);
    x = 16'h1111; y = 16'h1111; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("mid_busy_before", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_outs", {busy, done, xeqy, xgty, xlty}, 0);
    dn = 0;
    for (int i = 0; i < 6; i++) begin
      if (done || busy) dn++;
      tick();
    end
    chk("mid_rst_idle", dn, 0);
    run_cmp(16'h0F00, 16'h0E00, 2, 0, 1, 0, "post_rst");

`ifdef SERIAL_MAG_CMP_SIGNED_EN
    is_signed = 1'b1;
    run_cmp(16'hFFFF, 16'h0001, 1, 0, 0, 1, "signed_lt");
    is_signed = 1'b0;
    run_cmp(16'hFFFF, 16'h0001, 1, 0, 1, 0, "unsigned_gt");
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
